// File: rtl/mips_pkg.sv
// Shared pipeline definitions: GPR addressing, hazard FSM states, timeout default.
package mips_pkg;

   localparam int unsigned REG_ADDR_W        = 5;
   localparam int unsigned NUM_GPR           = 32;
   localparam int unsigned STALL_TIMEOUT_DEF = 64;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      HUNG  = 2'd2
   } hz_state_e;

endpackage

// File: rtl/sb_regfile_bits.sv
// Pending-write bit array: one bit per GPR, set on issue, cleared on writeback.
// A set and a clear on the same index in one cycle leave the bit set, so a
// WAW re-issue landing on the retiring writer never loses its pending bit.
// Bit 0 is hardwired low because $0 is never written.
module sb_regfile_bits
   import mips_pkg::*;
#(
   parameter int unsigned NUM_REGS = NUM_GPR
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_set_en,
   input  logic [REG_ADDR_W-1:0] i_set_idx,
   input  logic                  i_clr_en,
   input  logic [REG_ADDR_W-1:0] i_clr_idx,
   output logic [NUM_REGS-1:0]   o_pend
);

   logic [NUM_REGS-1:0] r_pend;
   logic [NUM_REGS-1:0] w_set_mask;
   logic [NUM_REGS-1:0] w_clr_mask;
   logic [NUM_REGS-1:0] w_next;

   // Decode set/clear and apply clear first so set takes priority
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (i_set_en) w_set_mask = NUM_REGS'(1) << i_set_idx;
      if (i_clr_en) w_clr_mask = NUM_REGS'(1) << i_clr_idx;
      w_next = ((r_pend & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);
   end

   // Scoreboard storage
   always_ff @(posedge clk) begin
      if (rst) r_pend <= '0;
      else     r_pend <= w_next;
   end

   assign o_pend = r_pend;

endmodule

// File: rtl/scoreboard_hazard_ctrl.sv
// Pipeline interlock: stalls IF/ID and bubbles EX while the ID instruction
// reads or rewrites a register with an outstanding write.
// Optional macro SCOREBOARD_WB_BYPASS_EN: a register being written back this
// cycle is treated as no longer pending (needs a write-through register file).
module scoreboard_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int unsigned NUM_REGS      = NUM_GPR,
   parameter int unsigned STALL_TIMEOUT = STALL_TIMEOUT_DEF,
   parameter int unsigned CNT_W         = 16
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_uses_rs,
   input  logic                  id_uses_rt,
   input  logic                  id_reg_write,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   output logic                  stall_if,
   output logic                  stall_id,
   output logic                  bubble_ex,
   output logic [NUM_REGS-1:0]   pending,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic                  hang
);

   localparam int unsigned RL_W = $clog2(STALL_TIMEOUT + 1);

   logic [NUM_REGS-1:0] w_pend;
   logic [NUM_REGS-1:0] w_pend_eff;
   logic                w_wb_clr;
   logic                w_set_en;
   logic                w_rs_hit;
   logic                w_rt_hit;
   logic                w_waw_hit;
   logic                w_hazard;
   logic                w_issue;
   logic [RL_W-1:0]     w_run_next;

   hz_state_e           r_state;
   logic [RL_W-1:0]     r_run_len;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic                r_hang;

   assign w_wb_clr = wb_reg_write && (wb_dest != '0);

`ifdef SCOREBOARD_WB_BYPASS_EN
   logic [NUM_REGS-1:0] w_wb_mask;
   assign w_wb_mask  = NUM_REGS'(1) << wb_dest;
   assign w_pend_eff = w_wb_clr ? (w_pend & ~w_wb_mask) : w_pend;
`else
   assign w_pend_eff = w_pend;
`endif

   // RAW on rs/rt and WAW on dest against the (possibly bypassed) scoreboard
   always_comb begin
      w_rs_hit  = id_uses_rs   && (id_rs   != '0) && (|(w_pend_eff & (NUM_REGS'(1) << id_rs)));
      w_rt_hit  = id_uses_rt   && (id_rt   != '0) && (|(w_pend_eff & (NUM_REGS'(1) << id_rt)));
      w_waw_hit = id_reg_write && (id_dest != '0) && (|(w_pend_eff & (NUM_REGS'(1) << id_dest)));
      w_hazard  = id_valid && (w_rs_hit || w_rt_hit || w_waw_hit);
      w_issue   = id_valid && !w_hazard;
      w_set_en  = w_issue && id_reg_write && (id_dest != '0);
   end

   sb_regfile_bits #(
      .NUM_REGS (NUM_REGS)
   ) u_bits (
      .clk       (clk),
      .rst       (rst),
      .i_set_en  (w_set_en),
      .i_set_idx (id_dest),
      .i_clr_en  (w_wb_clr),
      .i_clr_idx (wb_dest),
      .o_pend    (w_pend)
   );

   // Length of the current stall run including this cycle
   assign w_run_next = (r_state == STALL) ? (r_run_len + RL_W'(1)) : RL_W'(1);

   // Hazard FSM, run-length tracking, saturating stall counter, sticky hang
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RUN;
         r_run_len   <= '0;
         r_stall_cnt <= '0;
         r_hang      <= 1'b0;
      end else begin
         if (w_hazard && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         case (r_state)
            RUN, STALL: begin
               if (w_hazard) begin
                  r_run_len <= w_run_next;
                  if (w_run_next >= RL_W'(STALL_TIMEOUT)) begin
                     r_state <= HUNG;
                     r_hang  <= 1'b1;
                  end else begin
                     r_state <= STALL;
                  end
               end else begin
                  r_state   <= RUN;
                  r_run_len <= '0;
               end
            end
            HUNG: begin
               r_state <= HUNG;
               r_hang  <= 1'b1;
            end
            default: begin
               r_state   <= RUN;
               r_run_len <= '0;
            end
         endcase
      end
   end

   assign stall_if  = w_hazard;
   assign stall_id  = w_hazard;
   assign bubble_ex = w_hazard;
   assign pending   = w_pend;
   assign stall_cnt = r_stall_cnt;
   assign hang      = r_hang;

endmodule
